// File: rtl/pipe_hazard_ctrl_if.sv
// Groups the pipeline hazard-controller bus: hazard inputs from ID/EX plus stage controls back out.
// Latency: none, this is wiring only.
// Backpressure: none; mem_busy is the freeze request the controller honours.
//
// Ports (master drives the pipeline-side inputs, slave is the controller):
//   ID_EX_MemRead, ID_EX_RD         load-in-EX indication and its destination register
//   IF_ID_RS1/RS2, IF_ID_use_rs1/2  source registers of the ID instruction and whether they are read
//   branch_taken, mem_busy          redirect resolved in MEM, data memory not ready
//   PC_write .. EX_MEM_hold         per-stage load/flush/hold controls
//   mem_timeout, stall_cycles, flush_count  status and saturating performance counters
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_RD;
    logic [4:0]       IF_ID_RS1;
    logic [4:0]       IF_ID_RS2;
    logic             IF_ID_use_rs1;
    logic             IF_ID_use_rs2;
    logic             branch_taken;
    logic             mem_busy;
    logic             PC_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic             EX_MEM_flush;
    logic             ID_EX_hold;
    logic             EX_MEM_hold;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ID_EX_MemRead, ID_EX_RD, IF_ID_RS1, IF_ID_RS2,
               IF_ID_use_rs1, IF_ID_use_rs2, branch_taken, mem_busy,
        input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
               ID_EX_hold, EX_MEM_hold, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_RD, IF_ID_RS1, IF_ID_RS2,
               IF_ID_use_rs1, IF_ID_use_rs2, branch_taken, mem_busy,
        output PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
               ID_EX_hold, EX_MEM_hold, mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze, timeout and perf counters.
// Latency: stage controls are combinational from state and inputs (zero cycles); status/counters registered.
// Backpressure: mem_busy freezes PC, IF/ID, ID/EX and EX/MEM; a branch seen while frozen is deferred.
//
// Ports: clk (rising edge), rst (async, active-low), hif (pipe_hazard_ctrl_if.slave).
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hif
);

    typedef enum logic [1:0] {RUN, LOADUSE, MEMWAIT} state_t;

    localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state, state_nxt;
    logic             br_pend, br_pend_nxt;
    logic [7:0]       wait_cnt;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic hz, branch, br_flush;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, id_ex_hold, ex_mem_hold;

    // Load-use hazard: a load in EX writes a register the ID instruction reads (x0 never hazards).
    assign hz = hif.ID_EX_MemRead && (hif.ID_EX_RD != 5'd0) &&
                ((hif.IF_ID_use_rs1 && (hif.ID_EX_RD == hif.IF_ID_RS1)) ||
                 (hif.IF_ID_use_rs2 && (hif.ID_EX_RD == hif.IF_ID_RS2)));

    // A branch resolved while memory was busy is remembered and acted on once the freeze lifts.
    assign branch = hif.branch_taken || br_pend;

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        id_ex_hold   = 1'b0;
        ex_mem_hold  = 1'b0;
        br_flush     = 1'b0;
        state_nxt    = RUN;
        br_pend_nxt  = br_pend;
        if (rst) begin
            // Every legal state applies the same priority; the state records which stall is in
            // progress and an illegal encoding falls back to RUN with normal controls.
            unique case (state)
                RUN, LOADUSE, MEMWAIT: begin
                    if (hif.mem_busy) begin
                        id_ex_hold  = 1'b1;
                        ex_mem_hold = 1'b1;
                        br_pend_nxt = br_pend || hif.branch_taken;
                        state_nxt   = MEMWAIT;
                    end else if (branch) begin
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        br_flush     = 1'b1;
                        br_pend_nxt  = 1'b0;
                    end else if (hz) begin
                        id_ex_flush = 1'b1;
                        state_nxt   = LOADUSE;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
                default: begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            br_pend     <= 1'b0;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            br_pend <= br_pend_nxt;
            if (hif.mem_busy) begin
                if (wait_cnt != 8'hFF) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                if (wait_cnt == WAIT_LAST) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= 8'd0;
            end
            if (!pc_write && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (br_flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign hif.PC_write     = pc_write;
    assign hif.IF_ID_write  = if_id_write;
    assign hif.IF_ID_flush  = if_id_flush;
    assign hif.ID_EX_flush  = id_ex_flush;
    assign hif.EX_MEM_flush = ex_mem_flush;
    assign hif.ID_EX_hold   = id_ex_hold;
    assign hif.EX_MEM_hold  = ex_mem_hold;
    assign hif.mem_timeout  = mem_timeout;
    assign hif.stall_cycles = stall_cnt;
    assign hif.flush_count  = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
// Latency: expectations are queued at drive time and compared on the following falling edge.
// Backpressure: not applicable; the DUT presents a result every cycle.
module tb_pipe_hazard_ctrl;

    localparam int T    = 64;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) hif ();

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    // ctrl = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, ID_EX_hold, EX_MEM_hold}
    typedef struct {
        logic [6:0] ctrl;
        logic       tmo;
        int         stall;
        int         flush;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: pending branch, consecutive busy cycles, sticky timeout, counters.
    bit m_br_pend = 1'b0;
    bit m_tmo     = 1'b0;
    int m_busy_run = 0;
    int m_stall    = 0;
    int m_flush    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit u1, input bit u2, input bit bt, input bit mb);
        exp_t e;
        bit   hz, br;
        @(posedge clk);
        #1;
        rst                = r;
        hif.ID_EX_MemRead  = mr;
        hif.ID_EX_RD       = rd;
        hif.IF_ID_RS1      = rs1;
        hif.IF_ID_RS2      = rs2;
        hif.IF_ID_use_rs1  = u1;
        hif.IF_ID_use_rs2  = u2;
        hif.branch_taken   = bt;
        hif.mem_busy       = mb;
        if (!r) begin
            e.ctrl = 7'b0; e.tmo = 1'b0; e.stall = 0; e.flush = 0;
            m_br_pend = 1'b0; m_tmo = 1'b0; m_busy_run = 0; m_stall = 0; m_flush = 0;
        end else begin
            hz = mr && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
            br = bt || m_br_pend;
            e.tmo   = m_tmo;
            e.stall = m_stall;
            e.flush = m_flush;
            if (mb)      e.ctrl = 7'b0000011;
            else if (br) e.ctrl = 7'b1111100;
            else if (hz) e.ctrl = 7'b0001000;
            else         e.ctrl = 7'b1100000;
            if (!e.ctrl[6]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (!mb && br)  m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            if (mb) begin
                m_br_pend  = m_br_pend || bt;
                m_busy_run = m_busy_run + 1;
                if (m_busy_run >= T) m_tmo = 1'b1;
            end else begin
                m_busy_run = 0;
                m_br_pend  = 1'b0;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic busy(input bit bt);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, bt, 1'b1);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("ctrl", int'({hif.PC_write, hif.IF_ID_write, hif.IF_ID_flush, hif.ID_EX_flush,
                                hif.EX_MEM_flush, hif.ID_EX_hold, hif.EX_MEM_hold}), int'(mon_e.ctrl));
            check("mem_timeout", int'(hif.mem_timeout), int'(mon_e.tmo));
            check("stall_cycles", int'(hif.stall_cycles), mon_e.stall);
            check("flush_count", int'(hif.flush_count), mon_e.flush);
        end
    end

    initial begin
        hif.ID_EX_MemRead = 1'b0; hif.ID_EX_RD = 5'd0; hif.IF_ID_RS1 = 5'd0; hif.IF_ID_RS2 = 5'd0;
        hif.IF_ID_use_rs1 = 1'b0; hif.IF_ID_use_rs2 = 1'b0; hif.branch_taken = 1'b0; hif.mem_busy = 1'b0;

        // Reset state, then first cycle after release is normal.
        do_reset();
        idle();

        // Load-use on RS1: one bubble, then normal with one stall counted.
        drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        idle();

        // No hazard: RD=x0, and RS2 match with use_rs2 clear; RS2 match with use_rs2 set stalls.
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        // Hazard and branch together: branch wins.
        do_reset();
        drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();

        // Busy for 3 cycles, branch in busy cycle 2: deferred flush when busy drops.
        do_reset();
        busy(1'b0);
        busy(1'b1);
        busy(1'b0);
        idle();
        idle();

        // Memory wait timeout: sticky until reset.
        do_reset();
        repeat (T) busy(1'b0);
        idle();
        idle();
        do_reset();
        idle();

        // Reset in MEMWAIT with a pending branch discards it.
        busy(1'b0);
        busy(1'b1);
        do_reset();
        idle();
        idle();

        // Random traffic with occasional resets; small register range for frequent matches.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 4) == 0));
        end
        // Long busy burst inside random state to reach timeout again.
        repeat (T + 3) busy(1'($urandom_range(0, 9) == 0));
        idle();
        idle();

        @(negedge clk);
        #1;
        check("scoreboard_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, memory-wait cycles before the timeout flag sets (range 2..255).
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 ID_EX_MemRead  input  1  the instruction in EX is a load.
REQ-006 ID_EX_RD  input  5  destination register of the instruction in EX.
REQ-007 IF_ID_RS1, IF_ID_RS2  input  5 each  source registers of the instruction in ID.
REQ-008 IF_ID_use_rs1, IF_ID_use_rs2  input  1 each  the ID instruction reads RS1/RS2.
REQ-009 branch_taken  input  1  redirect resolved in MEM; PC target is valid this cycle.
REQ-010 mem_busy  input  1  data memory not ready; the pipeline must freeze.
REQ-011 PC_write, IF_ID_write  output  1 each  1 = register loads, 0 = register holds.
REQ-012 IF_ID_flush, ID_EX_flush, EX_MEM_flush  output  1 each  clear the stage to a bubble at the next edge.
REQ-013 ID_EX_hold, EX_MEM_hold  output  1 each  freeze the stage register.
REQ-014 mem_timeout  output  1  sticky: memory wait exceeded TIMEOUT_CYCLES.
REQ-015 stall_cycles, flush_count  output  CNT_W each  saturating performance counters.

Function
REQ-016 hz SHALL be computed combinationally as ID_EX_MemRead & (ID_EX_RD!=0) & ((IF_ID_use_rs1 & ID_EX_RD==IF_ID_RS1) | (IF_ID_use_rs2 & ID_EX_RD==IF_ID_RS2)).
REQ-017 FSM states SHALL be RUN, LOADUSE and MEMWAIT, held in a registered state; all pipe-control outputs SHALL be combinational from the state and the inputs, with zero latency.
REQ-018 Priority in every state SHALL be mem_busy > branch (branch_taken or br_pend) > hz > normal.
REQ-019 Normal behaviour: PC_write=1, IF_ID_write=1; all flush and hold outputs 0.
REQ-020 mem_busy=1 (any state): PC_write=0, IF_ID_write=0, ID_EX_hold=1, EX_MEM_hold=1, all flushes 0; next state MEMWAIT.
REQ-021 branch_taken=1 while mem_busy=1: set the br_pend register, and apply no flush that cycle.
REQ-022 Branch with mem_busy=0: IF_ID_flush=ID_EX_flush=EX_MEM_flush=1, PC_write=1, IF_ID_write=1; clear br_pend; next state RUN.
REQ-023 hz=1 with no branch and mem_busy=0: PC_write=0, IF_ID_write=0, ID_EX_flush=1 (one bubble); next state LOADUSE.
REQ-024 LOADUSE: outputs per REQ-018..023 from the current inputs; next state RUN unless a higher rule applies; a repeat hz in LOADUSE SHALL stall again (stay LOADUSE).
REQ-025 MEMWAIT with mem_busy=0 and no branch: normal outputs; next state RUN.
REQ-026 wait_cnt (8-bit) SHALL increment each cycle mem_busy=1 and clear when mem_busy=0; mem_timeout SHALL set when wait_cnt reaches TIMEOUT_CYCLES-1 with mem_busy=1, and clear only on reset.
REQ-027 stall_cycles SHALL increment on every cycle with PC_write=0; flush_count SHALL increment on every cycle with a branch flush; both SHALL saturate at all-ones.

Reset
REQ-028 While rst=0: state=RUN, br_pend=0, wait_cnt=0, mem_timeout=0, counters=0, PC_write=0, IF_ID_write=0, and all flush and hold outputs 0.
REQ-029 Reset assertion mid-MEMWAIT or mid-LOADUSE SHALL discard the pending branch and the stall immediately, with no glitch-free requirement on the outputs.
REQ-030 The first edge after rst rises SHALL see normal outputs (REQ-019) if all inputs are idle.

Verification
REQ-031 ID_EX_MemRead=1, RD=5, RS1=5, use_rs1=1 -> one cycle PC_write=0, IF_ID_write=0, ID_EX_flush=1; next cycle (MemRead=0) normal; stall_cycles=1.
REQ-032 RD=0 with MemRead=1 and RS1=0 -> no stall; RD=7 matching RS2 with use_rs2=0 -> no stall.
REQ-033 hz=1 and branch_taken=1 in the same cycle -> three flushes, PC_write=1, no stall; flush_count=1.
REQ-034 mem_busy high for 3 cycles with branch_taken pulsed in busy cycle 2 -> holds for 3 cycles, then one flush cycle when busy drops; stall_cycles=3, flush_count=1.
REQ-035 mem_busy held for 64 cycles with TIMEOUT_CYCLES=64 -> mem_timeout rises on busy cycle 64 and stays 1 after busy drops, until rst=0.
REQ-036 rst driven low during MEMWAIT with br_pend=1 -> after release there is no flush and all counters read 0.
